// File: rtl/fir_pkg.sv
// Shared helpers for the FIR / DWT datapath: width math and signed output limits.
// Latency: n/a (constant functions only).
// Backpressure: n/a.
package fir_pkg;

    // Ceiling log2, constant-evaluable; returns 0 for n <= 1.
    function automatic int fir_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Accumulator width that holds a full N-tap sum of products without overflow.
    function automatic int fir_w_acc(input int w_in, input int w_coef, input int n_taps);
        return w_in + w_coef + fir_clog2(n_taps);
    endfunction

    // Largest value representable in a w-bit two's complement word.
    function automatic longint fir_smax(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Most negative value representable in a w-bit two's complement word.
    function automatic longint fir_smin(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, arithmetic shift right by SHIFT, then saturate or wrap to W_OUT.
// Latency: combinational. Backpressure: none.
// Ports: acc_i (W_ACC signed accumulator), y_o (W_OUT signed result), ovf_o (clamp/wrap flag).
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int W_ACC  = 14,
    parameter int W_OUT  = 20,
    parameter int SHIFT  = 0,
    parameter int SAT_EN = 1
) (
    input  logic signed [W_ACC-1:0] acc_i,
    output logic signed [W_OUT-1:0] y_o,
    output logic                    ovf_o
);

    // The rounding add can carry into one extra bit, so the shifted result
    // keeps W_ACC+1-SHIFT bits rather than W_ACC-SHIFT.
    localparam int W_SH = (SHIFT > 0) ? (W_ACC + 1 - SHIFT) : W_ACC;

    logic signed [W_SH-1:0] sh;

    generate
        if (SHIFT > 0) begin : g_rnd
            logic signed [W_ACC:0] rnd;
            assign rnd = (W_ACC + 1)'(acc_i) + ((W_ACC + 1)'(1) <<< (SHIFT - 1));
            assign sh  = W_SH'(rnd >>> SHIFT);
        end else begin : g_nornd
            assign sh = acc_i;
        end

        if (W_OUT >= W_SH) begin : g_ext
            // Output is wide enough for every value: plain sign extension.
            assign y_o   = W_OUT'(sh);
            assign ovf_o = 1'b0;
        end else begin : g_lim
            // Result fits only if every bit from W_OUT-1 upward is a copy of the sign.
            logic [W_SH-W_OUT:0] top_bits;
            logic                over;
            assign top_bits = sh[W_SH-1:W_OUT-1];
            assign over     = !((&top_bits) || !(|top_bits));
            assign ovf_o    = over;

            if (SAT_EN != 0) begin : g_sat
                assign y_o = !over      ? sh[W_OUT-1:0] :
                             sh[W_SH-1] ? W_OUT'(fir_smin(W_OUT)) :
                                          W_OUT'(fir_smax(W_OUT));
            end else begin : g_wrap
                assign y_o = sh[W_OUT-1:0];
            end
        end
    endgenerate

endmodule

// File: rtl/fir_tn_cfg.sv
// N-tap transposed-form FIR with writable coefficients, valid qualifier, flush and round/sat output.
// Latency: 1 cycle from accepted sample to out_valid/y_out.
// Backpressure: none; every out_valid pulse must be consumed. Ports: clk/rst, coef_we/addr/data, flush, in_valid/x_in in; out_valid/y_out/ovf out.
module fir_tn_cfg
    import fir_pkg::*;
#(
    parameter int W_IN   = 7,
    parameter int W_COEF = 5,
    parameter int N_TAPS = 4,
    parameter int W_OUT  = 20,
    parameter int SHIFT  = 0,
    parameter int SAT_EN = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          coef_we,
    input  logic [fir_clog2(N_TAPS)-1:0]  coef_addr,
    input  logic signed [W_COEF-1:0]      coef_data,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic signed [W_IN-1:0]        x_in,
    output logic                          out_valid,
    output logic signed [W_OUT-1:0]       y_out,
    output logic                          ovf
);

    localparam int W_ACC = fir_w_acc(W_IN, W_COEF, N_TAPS);

    logic signed [W_COEF-1:0] coef_q [N_TAPS];
    // acc_q[j] holds the partial sum for tap j+1 (acc[1] .. acc[N-1]).
    logic signed [W_ACC-1:0]  acc_q  [N_TAPS-1];
    logic signed [W_ACC-1:0]  acc_d  [N_TAPS-1];
    logic signed [W_ACC-1:0]  prod   [N_TAPS];
    logic signed [W_ACC-1:0]  sum0;
    logic signed [W_OUT-1:0]  y_q, y_d;
    logic                     vld_q;
    logic                     ovf_q, ovf_d;

    // Products at full accumulator width; operands sign-extended first.
    always_comb begin
        for (int k = 0; k < N_TAPS; k++) begin
            prod[k] = W_ACC'(x_in) * W_ACC'(coef_q[k]);
        end
    end

    always_comb begin
        for (int j = 0; j < N_TAPS - 2; j++) begin
            acc_d[j] = acc_q[j+1] + prod[j+1];
        end
        acc_d[N_TAPS-2] = prod[N_TAPS-1];
    end

    assign sum0 = acc_q[0] + prod[0];

    fir_round_sat #(
        .W_ACC  (W_ACC),
        .W_OUT  (W_OUT),
        .SHIFT  (SHIFT),
        .SAT_EN (SAT_EN)
    ) u_round_sat (
        .acc_i (sum0),
        .y_o   (y_d),
        .ovf_o (ovf_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_TAPS; k++)     coef_q[k] <= '0;
            for (int j = 0; j < N_TAPS - 1; j++) acc_q[j]  <= '0;
            y_q   <= '0;
            vld_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            // Samples in this cycle still see the old coefficient (read before the edge).
            if (coef_we && (int'(coef_addr) < N_TAPS)) begin
                coef_q[coef_addr] <= coef_data;
            end

            if (flush) begin
                for (int j = 0; j < N_TAPS - 1; j++) acc_q[j] <= '0;
                vld_q <= 1'b0;
                ovf_q <= 1'b0;
            end else if (in_valid) begin
                for (int j = 0; j < N_TAPS - 1; j++) acc_q[j] <= acc_d[j];
                y_q   <= y_d;
                vld_q <= 1'b1;
                ovf_q <= ovf_d;
            end else begin
                vld_q <= 1'b0;
                ovf_q <= 1'b0;
            end
        end
    end

    assign out_valid = vld_q;
    assign y_out     = y_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fir_tn_cfg.sv
// Directed bench for fir_tn_cfg: four parameterisations share one stimulus stream.
// Latency: outputs checked 1 ns after the edge that registers them.
// Backpressure: n/a.
module tb_fir_tn_cfg;

    logic              clk;
    logic              rst;
    logic              coef_we;
    logic [1:0]        coef_addr;
    logic signed [4:0] coef_data;
    logic              flush;
    logic              in_valid;
    logic signed [6:0] x_in;

    logic               vld_b, ovf_b;
    logic signed [19:0] y_b;
    logic               vld_s, ovf_s;
    logic signed [9:0]  y_s;
    logic               vld_w, ovf_w;
    logic signed [9:0]  y_w;
    logic               vld_r, ovf_r;
    logic signed [19:0] y_r;

    int nvec;
    int nerr;

    fir_tn_cfg u_base (
        .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .flush(flush), .in_valid(in_valid), .x_in(x_in),
        .out_valid(vld_b), .y_out(y_b), .ovf(ovf_b)
    );

    fir_tn_cfg #(.W_OUT(10), .SHIFT(0), .SAT_EN(1)) u_sat (
        .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .flush(flush), .in_valid(in_valid), .x_in(x_in),
        .out_valid(vld_s), .y_out(y_s), .ovf(ovf_s)
    );

    fir_tn_cfg #(.W_OUT(10), .SHIFT(0), .SAT_EN(0)) u_wrap (
        .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .flush(flush), .in_valid(in_valid), .x_in(x_in),
        .out_valid(vld_w), .y_out(y_w), .ovf(ovf_w)
    );

    fir_tn_cfg #(.SHIFT(2)) u_rnd (
        .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .flush(flush), .in_valid(in_valid), .x_in(x_in),
        .out_valid(vld_r), .y_out(y_r), .ovf(ovf_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = a[1:0];
        coef_data = d[4:0];
        step();
        coef_we   = 1'b0;
    endtask

    task automatic smp(input int x);
        in_valid = 1'b1;
        x_in     = x[6:0];
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int imp [5];
        int rnd_x [3];
        int rnd_y [3];
        imp   = '{3, -2, 5, -16, 0};
        rnd_x = '{6, 5, -6};
        rnd_y = '{2, 1, -1};
        nvec = 0;
        nerr = 0;

        rst = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        flush = 1'b0; in_valid = 1'b0; x_in = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_vld", 32'(vld_b), 0);
        chk("rst_y",   y_b, 0);
        chk("rst_ovf", 32'(ovf_b), 0);

        // Impulse response, continuous valid.
        wr(0, 3); wr(1, -2); wr(2, 5); wr(3, -16);
        for (int i = 0; i < 5; i++) begin
            smp(i == 0 ? 1 : 0);
            chk("imp_y",   y_b, imp[i]);
            chk("imp_vld", 32'(vld_b), 1);
        end
        chk("imp_ovf", 32'(ovf_b), 0);

        // Same impulse with two idle cycles between samples.
        for (int i = 0; i < 5; i++) begin
            smp(i == 0 ? 1 : 0);
            chk("bub_y",   y_b, imp[i]);
            chk("bub_vld", 32'(vld_b), 1);
            for (int g = 0; g < 2; g++) begin
                step();
                chk("gap_vld", 32'(vld_b), 0);
                chk("gap_y",   y_b, imp[i]);
            end
        end

        // Rounding with SHIFT=2 on a single-tap response.
        wr(0, 1); wr(1, 0); wr(2, 0); wr(3, 0);
        for (int i = 0; i < 3; i++) begin
            smp(rnd_x[i]);
            chk("rnd_y", y_r, rnd_y[i]);
        end

        // Positive overflow: 4 * (-16 * -64) = 4096.
        wr(0, -16); wr(1, -16); wr(2, -16); wr(3, -16);
        for (int i = 0; i < 4; i++) smp(-64);
        chk("sat_y",    y_s, 511);
        chk("sat_ovf",  32'(ovf_s), 1);
        chk("wrap_y",   y_w, 0);
        chk("wrap_ovf", 32'(ovf_w), 1);
        chk("full_y",   y_b, 4096);
        chk("full_ovf", 32'(ovf_b), 0);

        // Negative overflow: 4 * (-16 * 63) = -4032, low 10 bits = 64.
        for (int i = 0; i < 4; i++) smp(63);
        chk("nsat_y",   y_s, -512);
        chk("nsat_ovf", 32'(ovf_s), 1);
        chk("nwrap_y",  y_w, 64);
        chk("full_ny",  y_b, -4032);

        // Flush at steady state.
        wr(0, 1); wr(1, 1); wr(2, 1); wr(3, 1);
        flush = 1'b1; step(); flush = 1'b0;
        chk("fl0_vld", 32'(vld_b), 0);
        for (int i = 0; i < 5; i++) begin
            smp(1);
            chk("ramp_y", y_b, (i < 4) ? i + 1 : 4);
        end
        flush = 1'b1; in_valid = 1'b1; x_in = 7'sd1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_vld",  32'(vld_b), 0);
        chk("fl_hold", y_b, 4);
        for (int i = 0; i < 4; i++) begin
            smp(1);
            chk("flr_y", y_b, i + 1);
        end

        // Coefficient write concurrent with a sample: old set used for that sample.
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = 5'sd2;
        smp(1);
        coef_we = 1'b0;
        chk("cupd_old", y_b, 4);
        smp(1);
        chk("cupd_new", y_b, 5);

        // Reset mid-stream overrides a concurrent sample and coefficient write.
        rst = 1'b1; in_valid = 1'b1; x_in = 7'sd1;
        coef_we = 1'b1; coef_addr = 2'd1; coef_data = 5'sd7;
        step();
        rst = 1'b0; in_valid = 1'b0; coef_we = 1'b0;
        chk("mrst_vld", 32'(vld_b), 0);
        chk("mrst_y",   y_b, 0);
        chk("mrst_ovf", 32'(ovf_b), 0);
        for (int i = 0; i < 2; i++) begin
            smp(1);
            chk("zc_y",   y_b, 0);
            chk("zc_vld", 32'(vld_b), 1);
        end
        wr(0, 3);
        smp(1);
        chk("reload_y", y_b, 3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
